clint_ctrl: RTL

- Core-local interrupt/exception controller for the pipelined RV32I core.
- Produces the `int_assert`/`int_addr` redirect that EX consumes.
- On trap entry: stalls EX, sequences the mepc/mcause/mstatus CSR writes, then redirects fetch to mtvec.
- On mret: restores mstatus, then redirects to mepc. Sits beside EX and the CSR file.

---
 rtl/clint_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/clint_ctrl.sv
// Core-local interrupt/exception controller: sequences the mepc/mcause/mstatus
// writes on trap entry (or the mstatus restore on mret) and then redirects fetch.
module clint_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_ecall,
    input  logic        ex_ebreak,
    input  logic        ex_mret,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mie,
    output logic        hold_flag_clint,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        int_assert,
    output logic [31:0] int_addr
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MEPC    = 3'd1,
        S_MCAUSE  = 3'd2,
        S_MSTATUS = 3'd3,
        S_MRET    = 3'd4,
        S_ASSERT  = 3'd5
    } state_t;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_MEI    = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MTI    = 32'h8000_0007;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [31:0] epc_r;
    logic [31:0] cause_r;
    logic        is_mret_r;

    logic        trigger_s;
    logic        trig_mret_s;
    logic [31:0] trig_cause_s;
    logic        mie_en_s;
    logic        unused_s;

    // Trap entry: MPIE takes the old MIE, interrupts are then disabled.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[7] = m[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // mret: MIE is restored from MPIE and MPIE is set.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[3] = m[7];
        r[7] = 1'b1;
        return r;
    endfunction

    assign mie_en_s = csr_mstatus[3];
    assign unused_s = ^{csr_mie[31:12], csr_mie[10:8], csr_mie[6:0], csr_mtvec[1:0]};

    // Prioritised trigger decode; only an IDLE controller with a valid EX slot can trigger.
    always_comb begin
        trigger_s    = 1'b0;
        trig_mret_s  = 1'b0;
        trig_cause_s = 32'd0;
        if ((state_r == S_IDLE) && ex_valid) begin
            if (ex_mret) begin
                trigger_s   = 1'b1;
                trig_mret_s = 1'b1;
            end else if (ex_ecall) begin
                trigger_s    = 1'b1;
                trig_cause_s = CAUSE_ECALL;
            end else if (ex_ebreak) begin
                trigger_s    = 1'b1;
                trig_cause_s = CAUSE_EBREAK;
            end else if (irq_ext && mie_en_s && csr_mie[11]) begin
                trigger_s    = 1'b1;
                trig_cause_s = CAUSE_MEI;
            end else if (irq_timer && mie_en_s && csr_mie[7]) begin
                trigger_s    = 1'b1;
                trig_cause_s = CAUSE_MTI;
            end else begin
                trigger_s = 1'b0;
            end
        end else begin
            trigger_s = 1'b0;
        end
    end

    // State register plus the trap context captured in the trigger cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            epc_r     <= 32'd0;
            cause_r   <= 32'd0;
            is_mret_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (trigger_s) begin
                epc_r     <= ex_pc;
                cause_r   <= trig_cause_s;
                is_mret_r <= trig_mret_s;
            end
        end
    end

    // Next-state sequencing; IRQ changes mid-sequence have no effect here.
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (trigger_s) begin
                    state_nxt_s = trig_mret_s ? S_MRET : S_MEPC;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_MEPC:    state_nxt_s = S_MCAUSE;
            S_MCAUSE:  state_nxt_s = S_MSTATUS;
            S_MSTATUS: state_nxt_s = S_ASSERT;
            S_MRET:    state_nxt_s = S_ASSERT;
            S_ASSERT:  state_nxt_s = S_IDLE;
            default:   state_nxt_s = S_IDLE;
        endcase
    end

    // Per-state outputs; EX stays held through S_ASSERT until the redirect cancels it.
    always_comb begin
        hold_flag_clint = 1'b0;
        csr_we          = 1'b0;
        csr_waddr       = 12'd0;
        csr_wdata       = 32'd0;
        int_assert      = 1'b0;
        int_addr        = 32'd0;
        case (state_r)
            S_IDLE: begin
                hold_flag_clint = trigger_s;
            end
            S_MEPC: begin
                hold_flag_clint = 1'b1;
                csr_we          = 1'b1;
                csr_waddr       = ADDR_MEPC;
                csr_wdata       = epc_r;
            end
            S_MCAUSE: begin
                hold_flag_clint = 1'b1;
                csr_we          = 1'b1;
                csr_waddr       = ADDR_MCAUSE;
                csr_wdata       = cause_r;
            end
            S_MSTATUS: begin
                hold_flag_clint = 1'b1;
                csr_we          = 1'b1;
                csr_waddr       = ADDR_MSTATUS;
                csr_wdata       = mstatus_on_trap(csr_mstatus);
            end
            S_MRET: begin
                hold_flag_clint = 1'b1;
                csr_we          = 1'b1;
                csr_waddr       = ADDR_MSTATUS;
                csr_wdata       = mstatus_on_mret(csr_mstatus);
            end
            S_ASSERT: begin
                hold_flag_clint = 1'b1;
                int_assert      = 1'b1;
                if (is_mret_r) begin
                    int_addr = csr_mepc;
                end else begin
                    int_addr = {csr_mtvec[31:2], 2'b00};
                end
            end
            default: begin
                hold_flag_clint = 1'b0;
            end
        endcase
    end

endmodule
